// File: rtl/board_double_buffer_pkg.sv
// Shared definitions for the board double buffer.
//   WORD_SIZE    : cells per memory word
//   LOG_MAX_ADDR : word address width
//   MAX_ADDR     : words per bank
//   DROP_CNT_W   : width of the dropped-frame counter
//   dbuf_state_t : swap/clear FSM states
package board_double_buffer_pkg;
  localparam int WORD_SIZE    = 8;
  localparam int LOG_MAX_ADDR = 4;
  localparam int MAX_ADDR     = 16;
  localparam int DROP_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_PENDING
  } dbuf_state_t;
endpackage

// File: rtl/board_double_buffer_bank.sv
// One board bank: MAX_ADDR x WORD_SIZE array.
//   clk          : clock
//   we/waddr/wdata : write port, commits on the clock edge
//   raddr/rdata  : combinational read port
//   qaddr/qdata  : registered read port (one-cycle latency)
module board_bank #(
  parameter int WORD_SIZE    = 8,
  parameter int LOG_MAX_ADDR = 4,
  parameter int MAX_ADDR     = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [LOG_MAX_ADDR-1:0] waddr,
  input  logic [WORD_SIZE-1:0]    wdata,
  input  logic [LOG_MAX_ADDR-1:0] raddr,
  output logic [WORD_SIZE-1:0]    rdata,
  input  logic [LOG_MAX_ADDR-1:0] qaddr,
  output logic [WORD_SIZE-1:0]    qdata
);
  logic [WORD_SIZE-1:0] mem [MAX_ADDR];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    qdata <= mem[qaddr];
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/board_double_buffer.sv
// Two-bank board store between life_logic and the display scanner.
//   clk_in/rst_n_in       : clock, async active-low reset
//   addr_r_in/data_r_out  : logic-side combinational read of the front bank
//   addr_w_in/data_w_in/wr_en_in : logic-side write into the back bank
//   logic_done_in         : generation-complete level from life_logic
//   start_out             : one-cycle generation start pulse
//   disp_addr_in/disp_data_out : display registered read of the front bank
//   frame_in              : start-of-vblank pulse; swaps happen here
//   front_sel_out         : index of the front bank
//   busy_out              : high while both banks are being cleared
//   drop_cnt_out          : saturating count of frames that came too early
module board_double_buffer
  import board_double_buffer_pkg::*;
#(
  parameter int WORD_SIZE    = board_double_buffer_pkg::WORD_SIZE,
  parameter int LOG_MAX_ADDR = board_double_buffer_pkg::LOG_MAX_ADDR,
  parameter int MAX_ADDR     = board_double_buffer_pkg::MAX_ADDR
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [LOG_MAX_ADDR-1:0] addr_r_in,
  output logic [WORD_SIZE-1:0]    data_r_out,
  input  logic [LOG_MAX_ADDR-1:0] addr_w_in,
  input  logic [WORD_SIZE-1:0]    data_w_in,
  input  logic                    wr_en_in,
  input  logic                    logic_done_in,
  output logic                    start_out,
  input  logic [LOG_MAX_ADDR-1:0] disp_addr_in,
  output logic [WORD_SIZE-1:0]    disp_data_out,
  input  logic                    frame_in,
  output logic                    front_sel_out,
  output logic                    busy_out,
  output logic [DROP_CNT_W-1:0]   drop_cnt_out
);
  localparam logic [LOG_MAX_ADDR-1:0] LAST_ADDR = LOG_MAX_ADDR'(MAX_ADDR - 1);

  dbuf_state_t                   state;
  logic [LOG_MAX_ADDR-1:0]       clr_cnt;
  logic                          clearing, swap, drop;
  logic [1:0]                    we;
  logic [LOG_MAX_ADDR-1:0]       waddr;
  logic [WORD_SIZE-1:0]          wdata;
  logic [1:0][WORD_SIZE-1:0]     rdata, qdata;
  logic                          disp_sel_q, disp_zero_q;

  assign clearing = (state == ST_CLEAR);
  // A done level in RUN together with frame is treated as PENDING+frame.
  assign swap  = frame_in & ((state == ST_PENDING) | ((state == ST_RUN) & logic_done_in));
  assign drop  = frame_in & ((state == ST_ARM) | ((state == ST_RUN) & ~logic_done_in));
  assign start_out = swap | (frame_in & (state == ST_IDLE));
  assign busy_out  = clearing;

  // Clear writes zero into both banks; otherwise only the back bank is writable.
  assign waddr = clearing ? clr_cnt : addr_w_in;
  assign wdata = clearing ? '0 : data_w_in;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b] = clearing | (wr_en_in & (front_sel_out != 1'(b)));
    board_bank #(
      .WORD_SIZE   (WORD_SIZE),
      .LOG_MAX_ADDR(LOG_MAX_ADDR),
      .MAX_ADDR    (MAX_ADDR)
    ) u_bank (
      .clk  (clk_in),
      .we   (we[b]),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(addr_r_in),
      .rdata(rdata[b]),
      .qaddr(disp_addr_in),
      .qdata(qdata[b])
    );
  end

  assign data_r_out = rdata[front_sel_out];
  // Bank select and clear-force are registered alongside the bank read so the
  // display word always comes from the bank that was front at the read edge.
  assign disp_data_out = disp_zero_q ? '0 : qdata[disp_sel_q];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_CLEAR;
      clr_cnt       <= '0;
      front_sel_out <= 1'b0;
      drop_cnt_out  <= '0;
      disp_sel_q    <= 1'b0;
      disp_zero_q   <= 1'b1;
    end else begin
      disp_sel_q  <= front_sel_out;
      disp_zero_q <= clearing;
      if (drop && drop_cnt_out != '1) drop_cnt_out <= drop_cnt_out + DROP_CNT_W'(1);
      if (swap) front_sel_out <= ~front_sel_out;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + LOG_MAX_ADDR'(1);
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            state   <= ST_IDLE;
          end
        end
        ST_IDLE:    if (frame_in) state <= ST_ARM;
        // Ignore the done level life_logic still holds from the last generation.
        ST_ARM:     if (!logic_done_in) state <= ST_RUN;
        ST_RUN:     if (logic_done_in) state <= frame_in ? ST_ARM : ST_PENDING;
        ST_PENDING: if (frame_in) state <= ST_ARM;
        default:    state <= ST_CLEAR;
      endcase
    end
  end
endmodule

// File: doc/board_double_buffer.md
# board_double_buffer

Two-bank board store between `life_logic` and the video path. The front bank holds the current generation. `life_logic` reads from the front bank and writes into the back bank, while the display scanner reads the front bank. On a frame boundary after a completed generation, the block swaps banks and pulses the start of the next generation.

## Interface
Parameters:
- `WORD_SIZE`, default `WORD_SIZE` from common package: cells per memory word.
- `LOG_MAX_ADDR`, default `LOG_MAX_ADDR` from common package: word address width.
- `MAX_ADDR`, default `MAX_ADDR` from common package: words per bank.

Ports:
- `clk_in`  in  1  system clock; the block uses this one clock only.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `addr_r_in`  in  LOG_MAX_ADDR  logic-side read address (front bank).
- `data_r_out`  out  WORD_SIZE  logic-side read data, combinational.
- `addr_w_in`  in  LOG_MAX_ADDR  logic-side write address (back bank).
- `data_w_in`  in  WORD_SIZE  logic-side write data.
- `wr_en_in`  in  1  logic-side write strobe.
- `logic_done_in`  in  1  generation-complete level from `life_logic`.
- `start_out`  out  1  one-cycle pulse that starts a generation.
- `disp_addr_in`  in  LOG_MAX_ADDR  display read address (front bank).
- `disp_data_out`  out  WORD_SIZE  display read data, registered.
- `frame_in`  in  1  one-cycle pulse at the start of vertical blank.
- `front_sel_out`  out  1  index of the front bank.
- `busy_out`  out  1  high while the banks are being cleared.
- `drop_cnt_out`  out  8  saturating count of frames that arrived before a generation finished.

## Operation
- The FSM has five states: CLEAR, IDLE, ARM, RUN, PENDING.
- CLEAR:
  - Entered on reset.
  - A clear counter steps 0..MAX_ADDR-1, writing 0 to both banks at that address each cycle.
  - Logic-side writes are ignored; `disp_data_out` is forced to 0.
  - After address MAX_ADDR-1, the FSM goes to IDLE.
- IDLE: on `frame_in`, assert `start_out` for that cycle and go to ARM.
- ARM: wait for `logic_done_in` low, then go to RUN. This masks the stale done level that `life_logic` holds until it sees start.
- RUN: on `logic_done_in` high, go to PENDING.
- PENDING:
  - On `frame_in`: toggle `front_sel_out`, pulse `start_out`, go to ARM.
- Overrun: a `frame_in` seen in ARM or RUN increments `drop_cnt_out`, which saturates at 255. No swap occurs.
- Simultaneous events:
  - `logic_done_in` rising and `frame_in` in the same RUN cycle behave as PENDING with `frame_in`: swap, start, go to ARM. This is not counted as a drop.
- Writes land in the back bank (`!front_sel_out`) only, and only when `wr_en_in` is high and the state is not CLEAR.
- Reads:
  - `data_r_out` = front[`addr_r_in`].
  - `disp_data_out` <= front[`disp_addr_in`].
  - Neither read port ever reads the back bank.
- A swap takes effect for reads and writes from the cycle after the `frame_in` cycle.

## Timing
- Reset values:
  - `start_out`=0, `front_sel_out`=0, `busy_out`=1.
  - `disp_data_out`=0, `drop_cnt_out`=0.
  - State is CLEAR, clear counter is 0.
- Asserting reset mid-operation aborts at once. When reset is released, the clear sequence restarts from address 0.
- Clear takes exactly MAX_ADDR cycles. `busy_out` falls on the cycle IDLE is entered.
- `data_r_out` has 0-cycle latency, as `life_logic` requires. `disp_data_out` has 1-cycle latency.
- Writes commit at the clock edge where `wr_en_in`=1. A same-address front read never sees them, because they go to the other bank.
- `start_out` is never high in two consecutive cycles.

## Structure
- The common package gains:
  - `dbuf_state_t` enum for the FSM states.
  - `DROP_CNT_W` = 8.
- Sub-module `board_bank`, instantiated twice:
  - one `MAX_ADDR`×`WORD_SIZE` array;
  - one write port;
  - one combinational read port;
  - one registered read port.
- Bank muxing, the FSM and the clear counter live in the top level.

## Test plan
Bench parameters: `WORD_SIZE`=8, `MAX_ADDR`=16.
- **Reset and clear:** release reset and wait 16 cycles. Required: `busy_out` is 1 for exactly 16 cycles, and every word in both banks then reads 0x00.
- **Write isolation:** in RUN with front=0, write 0xA5 to address 3. Required: `data_r_out` at address 3 stays 0x00. After the next swap, `data_r_out` reads 0xA5, and `disp_data_out` reads 0xA5 one cycle after address 3 is presented.
- **Stale done:** hold `logic_done_in`=1, pulse `frame_in` in IDLE. Required: `start_out` pulses once and the FSM stays in ARM until done drops. Then raise done and pulse `frame_in`: the swap happens and `front_sel_out` goes 0→1.
- **Overrun:** pulse `frame_in` 3 times during RUN. Required: `drop_cnt_out`=3 and `front_sel_out` unchanged. With 300 such pulses, it saturates at 255.
- **Simultaneous done and frame:** in RUN, raise `logic_done_in` on the same cycle as `frame_in`. Required: swap and `start_out` on that cycle, `drop_cnt_out` unchanged.
- **Reset mid-run:** assert `rst_n_in`=0 during RUN with back-bank data written. Required: outputs return to reset values immediately, and after release both banks are cleared to 0.
